// File: rtl/mrhy4_pkg.sv
// mrhy4_pkg: shared types and constants for the mrHY4_Add word scheduler.
//   digit_t    : hybrid radix-4 digit {n2,p,pp}
//   ZERO_DIGIT : all-zero digit used for idle and flush slots
//   IDLE/STREAM/FLUSH/CLEAR : scheduler state encodings
//   tag_t      : per-slot result tag {valid,id,first,last}
package mrhy4_pkg;

  localparam int unsigned DIGIT_W  = 3;
  localparam int unsigned TAG_ID_W = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic n2;
    logic p;
    logic pp;
  } digit_t;

  localparam digit_t ZERO_DIGIT = 3'b000;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] CLEAR  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                first;
    logic                last;
  } tag_t;

endpackage

// File: rtl/mrhy4_rr_arb.sv
// mrhy4_rr_arb: one-hot arbiter over N requesters.
//   Default build: round-robin; search starts at an internal pointer which
//   moves to (granted index + 1) mod N whenever update is high.
//   MRHY4_SCHED_PRIO_EN defined: fixed priority, lowest index wins, no pointer.
// Ports: clk, rst (async active-high), req, update (a grant is being taken),
//        gnt_c (one-hot), gnt_id_c (index of gnt_c), any_c (some req is set).
module mrhy4_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 update,
  output logic [N-1:0]         gnt_c,
  output logic [$clog2(N)-1:0] gnt_id_c,
  output logic                 any_c
);

  localparam int unsigned ID_W = $clog2(N);

  logic [ID_W-1:0] start;
  logic            found;
  int              idx;

`ifdef MRHY4_SCHED_PRIO_EN
  assign start = '0;
  wire unused_arb = &{1'b0, clk, rst, update};
`else
  logic [ID_W-1:0] rr_ptr;

  // Pointer moves past the index just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (update) begin
      rr_ptr <= (int'(gnt_id_c) == int'(N) - 1) ? '0 : gnt_id_c + ID_W'(1);
    end
  end

  assign start = rr_ptr;
`endif

  // First requester found scanning upward (with wrap) from start.
  always_comb begin
    gnt_c    = '0;
    gnt_id_c = '0;
    found    = 1'b0;
    idx      = 0;
    any_c    = |req;
    for (int off = 0; off < int'(N); off++) begin
      idx = (int'(start) + off) % int'(N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        gnt_id_c   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mrhy4_add_sched.sv
// mrhy4_add_sched: shares one digit-serial mrHY4_Add adder among N_REQ
// requesters, one whole word per grant (DIGITS digits, a zero flush digit,
// then a clear slot), and returns tagged result digits.
// Ports: clk, rst (async active-high); req/in_valid/in_x/in_y per requester;
//        grant (one-hot, owner's STREAM phase); add_x/add_y/add_clr to the
//        adder, add_s from it; res_valid/res_id/res_digit/res_first/res_last
//        tagged result stream; err one-cycle abort pulse.
// Build option: MRHY4_SCHED_PRIO_EN selects fixed-priority arbitration.
import mrhy4_pkg::*;

module mrhy4_add_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [3*N_REQ-1:0]       in_x,
  input  logic [3*N_REQ-1:0]       in_y,
  output logic [N_REQ-1:0]         grant,
  output logic [2:0]               add_x,
  output logic [2:0]               add_y,
  output logic                     add_clr,
  input  logic [2:0]               add_s,
  output logic                     res_valid,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [2:0]               res_digit,
  output logic                     res_first,
  output logic                     res_last,
  output logic                     err
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned CNT_W  = $clog2(DIGITS);
  localparam int unsigned PIPE_D = ADD_LAT + 1;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] grant_n;
  logic [ID_W-1:0]  owner, owner_n;
  digit_t           add_x_n, add_y_n;
  logic             add_clr_n;
  logic             err_n;
  tag_t             tag_n;
  logic             abort_c;
  logic             arb_update_c;
  logic [N_REQ-1:0] arb_gnt_c;
  logic [ID_W-1:0]  arb_id_c;
  logic             arb_any_c;
  tag_t             pipe [PIPE_D];
  logic [PIPE_D-1:0] kill_c;
  tag_t             res_tag_c;

  mrhy4_rr_arb #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .update   (arb_update_c),
    .gnt_c    (arb_gnt_c),
    .gnt_id_c (arb_id_c),
    .any_c    (arb_any_c)
  );

  // Next state, operand and tag for the slot being issued this cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    grant_n      = grant;
    owner_n      = owner;
    add_x_n      = ZERO_DIGIT;
    add_y_n      = ZERO_DIGIT;
    add_clr_n    = 1'b0;
    err_n        = 1'b0;
    tag_n        = '0;
    abort_c      = 1'b0;
    arb_update_c = 1'b0;
    case (state)
      IDLE, CLEAR: begin
        add_clr_n = 1'b1;
        grant_n   = '0;
        cnt_n     = '0;
        state_n   = IDLE;
        if (arb_any_c) begin
          arb_update_c = 1'b1;
          grant_n      = arb_gnt_c;
          owner_n      = arb_id_c;
          state_n      = STREAM;
        end
      end
      STREAM: begin
        if (!in_valid[owner]) begin
          abort_c = 1'b1;
          err_n   = 1'b1;
          grant_n = '0;
          cnt_n   = '0;
          state_n = CLEAR;
        end else begin
          add_x_n     = digit_t'(in_x[3*owner +: 3]);
          add_y_n     = digit_t'(in_y[3*owner +: 3]);
          tag_n.valid = 1'b1;
          tag_n.id    = TAG_ID_W'(owner);
          tag_n.first = (cnt == '0);
          if (cnt == CNT_W'(DIGITS - 1)) begin
            cnt_n   = '0;
            grant_n = '0;
            state_n = FLUSH;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        tag_n.valid = 1'b1;
        tag_n.id    = TAG_ID_W'(owner);
        tag_n.last  = 1'b1;
        state_n     = CLEAR;
      end
      default: state_n = IDLE;
    endcase
  end

  // On abort, stages 0..cnt-1 hold the aborted word's digits; older stages
  // belong to the previous word and must survive.
  always_comb begin
    kill_c = '0;
    for (int s = 0; s < int'(PIPE_D); s++) begin
      kill_c[s] = abort_c && (s < int'(cnt));
    end
  end

  assign res_tag_c = kill_c[PIPE_D-1] ? '0 : pipe[PIPE_D-1];

  wire unused_tag = &{1'b0, res_tag_c.id};

  // All state, adder drive, tag pipe and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      grant     <= '0;
      owner     <= '0;
      add_x     <= ZERO_DIGIT;
      add_y     <= ZERO_DIGIT;
      add_clr   <= 1'b1;
      err       <= 1'b0;
      for (int s = 0; s < int'(PIPE_D); s++) pipe[s] <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_digit <= '0;
      res_first <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      grant   <= grant_n;
      owner   <= owner_n;
      add_x   <= add_x_n;
      add_y   <= add_y_n;
      add_clr <= add_clr_n;
      err     <= err_n;
      pipe[0] <= tag_n;
      for (int s = 1; s < int'(PIPE_D); s++) begin
        pipe[s] <= kill_c[s-1] ? '0 : pipe[s-1];
      end
      res_valid <= res_tag_c.valid;
      res_id    <= res_tag_c.id[ID_W-1:0];
      res_digit <= add_s;
      res_first <= res_tag_c.first;
      res_last  <= res_tag_c.last;
    end
  end

endmodule

// File: tb/tb_mrhy4_add_sched.sv
// tb_mrhy4_add_sched: self-checking bench for mrhy4_add_sched with a
// behavioural digit-serial adder (one-cycle latency) closing the loop.
module tb_mrhy4_add_sched;

  localparam int N_REQ   = 4;
  localparam int DIGITS  = 8;
  localparam int ADD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  in_valid = '0;
  logic [11:0] in_x = '0;
  logic [11:0] in_y = '0;
  logic [3:0]  grant;
  logic [2:0]  add_x, add_y;
  logic        add_clr;
  logic [2:0]  add_s = '0;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [2:0]  res_digit;
  logic        res_first, res_last, err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mrhy4_add_sched #(.N_REQ(N_REQ), .DIGITS(DIGITS), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .grant(grant), .add_x(add_x), .add_y(add_y), .add_clr(add_clr), .add_s(add_s),
    .res_valid(res_valid), .res_id(res_id), .res_digit(res_digit),
    .res_first(res_first), .res_last(res_last), .err(err)
  );

  function automatic int dval(input logic [2:0] d);
    return -2 * int'(d[2]) + int'(d[1]) + int'(d[0]);
  endfunction

  function automatic logic [2:0] enc(input int v);
    case (v)
      -2:      return 3'b100;
      -1:      return 3'b110;
      1:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Behavioural adder: digit in [-2,1] plus carry in [-1,1], sync clear.
  int acc_c = 0;
  always @(posedge clk) begin
    int w;
    int cn;
    if (add_clr) begin
      acc_c <= 0;
      add_s <= 3'b000;
    end else begin
      w = dval(add_x) + dval(add_y) + acc_c;
      cn = (w + 6) / 4 - 1;
      acc_c <= cn;
      add_s <= enc(w - 4 * cn);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int         id;
    logic [2:0] xd;
    logic [2:0] yd;
    int         exp_val;
  } vec_t;

  vec_t vecs[5];

  // One full word from a single requester; checks framing, timing and value.
  task automatic run_word(input int id, input logic [2:0] xd, input logic [2:0] yd,
                          input int exp_val);
    int got = -1;
    int gcnt = 0, rcnt = 0, val = 0, p4 = 1, idbad = 0, lat = -1;
    int firsts = 0, first_at = -1, lasts = 0, last_at = -1, clr_bad = 0, x_bad = 0;
    int exp_clr;
    logic [2:0] exp_x;
    req[id] = 1'b1;
    in_valid[id] = 1'b1;
    in_x[3*id +: 3] = xd;
    in_y[3*id +: 3] = yd;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (grant[id]) begin
        got = t;
        break;
      end
    end
    check($sformatf("grant_seen_id%0d", id), int'(got >= 0), 1);
    req[id] = 1'b0;
    if (got < 0) begin
      in_valid[id] = 1'b0;
      return;
    end
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (grant[id]) gcnt++;
      exp_clr = (k == 0 || k >= 10) ? 1 : 0;
      if (int'(add_clr) != exp_clr) clr_bad++;
      exp_x = (k >= 1 && k <= DIGITS) ? xd : 3'b000;
      if (add_x != exp_x) x_bad++;
      if (res_valid) begin
        if (lat < 0) lat = k;
        if (int'(res_id) != id) idbad++;
        if (res_first) begin firsts++; first_at = rcnt; end
        if (res_last) begin lasts++; last_at = rcnt; end
        val += dval(res_digit) * p4;
        p4 *= 4;
        rcnt++;
      end
    end
    in_valid[id] = 1'b0;
    check("grant_cycles", gcnt, DIGITS);
    check("res_count", rcnt, DIGITS + 1);
    check("res_latency", lat, ADD_LAT + 2);
    check("res_id_bad", idbad, 0);
    check("first_count", firsts, 1);
    check("first_pos", first_at, 0);
    check("last_count", lasts, 1);
    check("last_pos", last_at, DIGITS);
    check("add_clr_bad", clr_bad, 0);
    check("add_x_bad", x_bad, 0);
    check($sformatf("sum_value_id%0d", id), val, exp_val);
  endtask

  initial begin
    int owners[4];
    int rise_t[4];
    int exp_own[4];
    int nr;
    logic [3:0] prev;
    int got, g2cnt, errcnt, err_at, late_valid, lasts2, next_owner, next_at, post_valid, post_grant;

    // Each word is DIGITS copies of one digit, so value = (vx+vy)*(4^8-1)/3.
    vecs[0] = '{0, 3'b010, 3'b000,  21845};
    vecs[1] = '{1, 3'b011, 3'b011,  87380};
    vecs[2] = '{2, 3'b100, 3'b010, -21845};
    vecs[3] = '{3, 3'b000, 3'b000,      0};
    vecs[4] = '{0, 3'b110, 3'b011,  21845};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", int'(grant), 0);
    check("rst_add_clr", int'(add_clr), 1);
    check("rst_add_x", int'(add_x), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_word(vecs[v].id, vecs[v].xd, vecs[v].yd, vecs[v].exp_val);
      repeat (2) @(negedge clk);
    end

    // Two contending requesters, back-to-back words
`ifdef MRHY4_SCHED_PRIO_EN
    exp_own = '{1, 1, 1, 1};
`else
    exp_own = '{1, 3, 1, 3};
`endif
    owners = '{-1, -1, -1, -1};
    rise_t = '{0, 0, 0, 0};
    nr = 0;
    prev = '0;
    req[1] = 1'b1; req[3] = 1'b1;
    in_valid[1] = 1'b1; in_valid[3] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (grant != 0 && prev == 0 && nr < 4) begin
        owners[nr] = onehot_idx(grant);
        rise_t[nr] = t;
        nr++;
        if (nr == 4) begin req[1] = 1'b0; req[3] = 1'b0; end
      end
      prev = grant;
    end
    in_valid[1] = 1'b0; in_valid[3] = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("alt_owner%0d", i), owners[i], exp_own[i]);
    for (int i = 1; i < 4; i++) check($sformatf("alt_gap%0d", i), rise_t[i] - rise_t[i-1], DIGITS + 2);
    repeat (5) @(negedge clk);

    // Owner 2 drops in_valid at digit 4
    got = -1;
    req[2] = 1'b1; in_valid[2] = 1'b1; in_x[8:6] = 3'b010; in_y[8:6] = 3'b000;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (grant[2]) begin got = t; break; end
    end
    check("abort_grant_seen", int'(got >= 0), 1);
    req[2] = 1'b0;
    g2cnt = 0; errcnt = 0; err_at = -1; late_valid = 0; lasts2 = 0;
    next_owner = -1; next_at = -1;
    prev = grant;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) @(negedge clk);
      if (grant[2]) g2cnt++;
      if (err) begin errcnt++; err_at = k; end
      if (res_valid && res_id == 2'd2 && k >= 5) late_valid++;
      if (res_valid && res_id == 2'd2 && res_last) lasts2++;
      if (k > 0 && grant != 0 && prev == 0 && next_owner < 0) begin
        next_owner = onehot_idx(grant);
        next_at = k;
      end
      prev = grant;
      if (k == 4) begin
        in_valid[2] = 1'b0;
        req[3] = 1'b1; in_valid[3] = 1'b1;
      end
      if (grant[3]) req[3] = 1'b0;
    end
    in_valid[3] = 1'b0;
    check("abort_err_count", errcnt, 1);
    check("abort_err_cycle", err_at, 5);
    check("abort_grant_cycles", g2cnt, 5);
    check("abort_late_valid", late_valid, 0);
    check("abort_res_last", lasts2, 0);
    check("abort_next_owner", next_owner, 3);
    check("abort_next_cycle", next_at, 6);
    repeat (5) @(negedge clk);

    // Reset asserted at STREAM digit 5
    got = -1;
    req[0] = 1'b1; in_valid[0] = 1'b1; in_x[2:0] = 3'b010; in_y[2:0] = 3'b000;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (grant[0]) begin got = t; break; end
    end
    check("rst_mid_grant_seen", int'(got >= 0), 1);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_grant", int'(grant), 0);
    check("rst_mid_add_clr", int'(add_clr), 1);
    check("rst_mid_add_x", int'(add_x), 0);
    check("rst_mid_res_valid", int'(res_valid), 0);
    check("rst_mid_res_first", int'(res_first), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    post_valid = 0; post_grant = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (res_valid) post_valid++;
      if (grant != 0) post_grant++;
    end
    check("rst_post_res_valid", post_valid, 0);
    check("rst_post_grant", post_grant, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mrhy4_add_sched.md
Name: mrhy4_add_sched

Overview:
- Time-multiplexes one hybrid-redundant radix-4 digit-serial adder (mrHY4_Add) between N_REQ digit-stream requesters in the ACFIR stream processor, e.g. tap-partial-sum producers.
- The adder carries internal digit state, so a grant covers one whole word. The block feeds DIGITS operand digits, then one zero flush digit to drain the final carry, then one clear cycle.
- Returns tagged result digits (DIGITS+1 per word) with requester id and word framing.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DIGITS, 8, operand digits per word (>=2).
- ADD_LAT, 1, cycles from a digit entering the adder to its result digit at add_s*; the tag pipeline is matched to it.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester word request, level; held until grant is seen.
- in_valid  in  N_REQ  per-requester digit valid.
- in_x  in  3*N_REQ  per-requester X digit {xn2,xp,xpp}, requester i at [3i+2:3i].
- in_y  in  3*N_REQ  per-requester Y digit {yn2,yp,ypp}, same packing.
- grant  out  N_REQ  one-hot, high for the whole STREAM phase of the owner.
- add_x  out  3  {xn2,xp,xpp} to the adder.
- add_y  out  3  {yn2,yp,ypp} to the adder.
- add_clr  out  1  drives the adder rst (synchronous clear of adder state).
- add_s  in  3  {sn2,sp,spp} from the adder.
- res_valid  out  1  result digit valid.
- res_id  out  $clog2(N_REQ)  owner of the result digit.
- res_digit  out  3  registered copy of add_s.
- res_first  out  1  first result digit of a word.
- res_last  out  1  final (DIGITS+1-th) result digit of a word.
- err  out  1  one-cycle pulse: stream aborted.

Behaviour:
- Reset (async): state=IDLE, grant=0, add_clr=1, add_x=add_y=ZERO_DIGIT, res_*=0, err=0, rr_ptr=0, digit counter=0, tag pipe cleared.
- States:
  - IDLE: add_clr=1, operands=ZERO_DIGIT. If any req is set, arbitrate, load grant, then STREAM.
  - STREAM: add_clr=0. Each cycle forwards the owner's in_x/in_y to add_x/add_y (registered: the digit sampled in cycle t reaches the adder in t+1). The counter runs 0..DIGITS-1. After DIGITS digits go to FLUSH.
  - FLUSH: 1 cycle. Drives ZERO_DIGIT on both operands with add_clr=0, so the adder emits its carry-out digit.
  - CLEAR: 1 cycle. add_clr=1, grant=0. Arbitration is evaluated here. If a request is pending, go directly to STREAM; otherwise go to IDLE.
- Occupancy: DIGITS+2 cycles per word back-to-back. Throughput is DIGITS/(DIGITS+2) digits per cycle.
- Arbitration: round-robin. The search starts at rr_ptr. On grant, rr_ptr = granted index + 1 mod N_REQ. A req that appears in the same cycle as a grant decision participates in that decision.
- Digit handshake: the owner must hold in_valid=1 for all DIGITS STREAM cycles.
  - If in_valid=0 in any STREAM cycle, the word is aborted: err pulses once, the partial results are discarded (their res_valid is suppressed), and the state goes to CLEAR.
  - rr_ptr still advances after an abort.
- The owner dropping req mid-STREAM is ignored; only in_valid matters.
- Result path:
  - Each digit slot carries a tag {valid, id, first, last} through ADD_LAT+1 register stages, aligned with the registered res_digit.
  - The first STREAM digit is tagged first. The FLUSH digit is tagged last. CLEAR and IDLE slots are tagged invalid.
  - res_* latency from in_x sampled: ADD_LAT+2 cycles.
- Mid-operation reset: everything returns to reset values immediately. Tags in flight are dropped and no res_last is emitted.
- The adder's own rst input is add_clr only. Top-level rst is not wired to the adder directly.

Optional Feature:
- MRHY4_SCHED_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is removed, and requester 0 can starve the others.
- Undefined: round-robin as above.
- The ports are identical in both builds.

Decomposition:
- Package mrhy4_pkg holds:
  - digit_t: 3-bit packed {n2,p,pp}.
  - ZERO_DIGIT = 3'b000.
  - state enum {IDLE, STREAM, FLUSH, CLEAR}.
  - tag_t struct {valid, id, first, last}.
- One natural sub-module: mrhy4_rr_arb (N_REQ one-hot round-robin or priority arbiter with pointer update). The FSM, counter and tag pipe stay in the top.

Test Plan:
- Single requester 0, DIGITS=8, in_valid steady → grant[0] for 8 cycles. Then FLUSH and CLEAR, with add_clr high only in CLEAR. 9 res_valid digits with res_id=0, res_first on the 1st and res_last on the 9th.
- Adder result check: X digits all encoding +1, Y all zero → res_digit stream equals a golden model of X+Y including the carry digit.
- Requesters 1 and 3 both holding req → grants alternate 1,3,1,3. Back-to-back words are 10 cycles apart with no IDLE cycle between them.
- Owner 2 drops in_valid at digit 4 → err pulses once and state goes to CLEAR. No res_last and no res_valid for that word. The next grant goes to index 3 (or wraps to 0).
- rst asserted in STREAM digit 5 → outputs at reset values within the same cycle (async), add_clr=1, no further res_valid.
- With MRHY4_SCHED_PRIO_EN defined and req=4'b1011 held → only requester 0 is granted, repeatedly.
